touch_hole_decoder: RTL

TOUCH_HOLE_DECODER -- requirements
Module: touch_hole_decoder

---
 rtl/touch_hole_decoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/touch_hole_decoder.sv
// Debounces touch-panel presses, maps a confirmed touch onto a COLS x ROWS hole grid,
// and reports one hit/miss pulse per press with the latched cell index and coordinates.
module touch_hole_decoder #(
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned REL_CYC = 8,
  parameter int unsigned X_ORG   = 40,
  parameter int unsigned Y_ORG   = 40,
  parameter int unsigned CELL_W  = 240,
  parameter int unsigned CELL_H  = 133,
  parameter int unsigned COLS    = 3,
  parameter int unsigned ROWS    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        touch_valid,
  input  logic [15:0] tp_x_coord,
  input  logic [15:0] tp_y_coord,
  input  logic        game_en,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [3:0]  hit_idx,
  output logic [15:0] hit_x,
  output logic [15:0] hit_y,
  output logic        pressed
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, DECODE, HELD} state_t;

  localparam logic [8:0]  DEB_LIM = 9'(DEB_CYC);
  localparam logic [8:0]  REL_LIM = 9'(REL_CYC);
  localparam logic [31:0] X_END   = 32'(X_ORG + COLS * CELL_W);
  localparam logic [31:0] Y_END   = 32'(Y_ORG + ROWS * CELL_H);
  localparam logic [3:0]  COLS4   = 4'(COLS);

  state_t      state_reg, state_next;
  logic [7:0]  deb_cnt_reg, deb_cnt_next;
  logic [7:0]  rel_cnt_reg, rel_cnt_next;
  logic [15:0] lat_x_reg, lat_x_next;
  logic [15:0] lat_y_reg, lat_y_next;
  logic        hit_pulse_reg, hit_pulse_next;
  logic        miss_pulse_reg, miss_pulse_next;
  logic [3:0]  hit_idx_reg, hit_idx_next;
  logic [15:0] hit_x_reg, hit_x_next;
  logic [15:0] hit_y_reg, hit_y_next;
  logic        pressed_reg, pressed_next;

  // Grid decode: one comparator per column/row boundary; 32-bit compares cannot wrap.
  logic [31:0]     x_ext, y_ext;
  logic [COLS-1:0] col_ge;
  logic [ROWS-1:0] row_ge;
  logic [3:0]      col, row, idx_calc;
  logic            in_grid;

  assign x_ext = {16'd0, lat_x_reg};
  assign y_ext = {16'd0, lat_y_reg};

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign col_ge[gi] = (x_ext >= 32'(X_ORG + gi * CELL_W));
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_ge[gi] = (y_ext >= 32'(Y_ORG + gi * CELL_H));
    end
  endgenerate

  // Boundaries are monotonic, so the count of passed boundaries is the index.
  always_comb begin
    col = 4'd0;
    row = 4'd0;
    for (int i = 1; i < COLS; i++) col = col + {3'd0, col_ge[i]};
    for (int i = 1; i < ROWS; i++) row = row + {3'd0, row_ge[i]};
  end

  assign in_grid  = col_ge[0] && (x_ext < X_END) && row_ge[0] && (y_ext < Y_END);
  assign idx_calc = row * COLS4 + col;

  always_comb begin
    state_next      = state_reg;
    deb_cnt_next    = deb_cnt_reg;
    rel_cnt_next    = rel_cnt_reg;
    lat_x_next      = lat_x_reg;
    lat_y_next      = lat_y_reg;
    hit_pulse_next  = 1'b0;
    miss_pulse_next = 1'b0;
    hit_idx_next    = hit_idx_reg;
    hit_x_next      = hit_x_reg;
    hit_y_next      = hit_y_reg;
    pressed_next    = pressed_reg;

    if (!game_en) begin
      state_next   = IDLE;
      deb_cnt_next = 8'd0;
      rel_cnt_next = 8'd0;
      pressed_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (touch_valid) begin
            lat_x_next   = tp_x_coord;
            lat_y_next   = tp_y_coord;
            deb_cnt_next = 8'd1;
            rel_cnt_next = 8'd0;
            state_next   = (DEB_LIM <= 9'd1) ? DECODE : DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (touch_valid) begin
            lat_x_next   = tp_x_coord;
            lat_y_next   = tp_y_coord;
            deb_cnt_next = deb_cnt_reg + 8'd1;
            if (({1'b0, deb_cnt_reg} + 9'd1) >= DEB_LIM) state_next = DECODE;
          end else begin
            deb_cnt_next = 8'd0;
            state_next   = IDLE;
          end
        end
        DECODE: begin
          hit_pulse_next  = in_grid;
          miss_pulse_next = !in_grid;
          hit_idx_next    = in_grid ? idx_calc : 4'd0;
          hit_x_next      = lat_x_reg;
          hit_y_next      = lat_y_reg;
          pressed_next    = 1'b1;
          deb_cnt_next    = 8'd0;
          rel_cnt_next    = 8'd0;
          state_next      = HELD;
        end
        HELD: begin
          // Any high sample restarts the release count, so glitches never re-trigger.
          if (touch_valid) begin
            rel_cnt_next = 8'd0;
          end else if (({1'b0, rel_cnt_reg} + 9'd1) >= REL_LIM) begin
            rel_cnt_next = 8'd0;
            pressed_next = 1'b0;
            state_next   = IDLE;
          end else begin
            rel_cnt_next = rel_cnt_reg + 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      deb_cnt_reg    <= 8'd0;
      rel_cnt_reg    <= 8'd0;
      lat_x_reg      <= 16'd0;
      lat_y_reg      <= 16'd0;
      hit_pulse_reg  <= 1'b0;
      miss_pulse_reg <= 1'b0;
      hit_idx_reg    <= 4'd0;
      hit_x_reg      <= 16'd0;
      hit_y_reg      <= 16'd0;
      pressed_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      deb_cnt_reg    <= deb_cnt_next;
      rel_cnt_reg    <= rel_cnt_next;
      lat_x_reg      <= lat_x_next;
      lat_y_reg      <= lat_y_next;
      hit_pulse_reg  <= hit_pulse_next;
      miss_pulse_reg <= miss_pulse_next;
      hit_idx_reg    <= hit_idx_next;
      hit_x_reg      <= hit_x_next;
      hit_y_reg      <= hit_y_next;
      pressed_reg    <= pressed_next;
    end
  end

  assign hit_pulse  = hit_pulse_reg;
  assign miss_pulse = miss_pulse_reg;
  assign hit_idx    = hit_idx_reg;
  assign hit_x      = hit_x_reg;
  assign hit_y      = hit_y_reg;
  assign pressed    = pressed_reg;

endmodule
